// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The master side is the host link plus memory observer. The slave side is the loader.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte image over a valid/ready
// stream and writes it into program memory starting at BASE_ADDR. The
// processor is held in reset until a complete image has been loaded.
// Optional feature macro PROG_LOADER_CSUM_EN adds a trailing modulo-256
// checksum byte. A mismatch on that byte ends in the error state.
module prog_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  prog_loader_if.slave bus,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
`ifdef PROG_LOADER_CSUM_EN
    ST_CSUM = 3'd3,
    ST_ERR  = 3'd5,
`endif
    ST_DONE = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] count_q, count_d;      // bytes still expected in DATA; 256 when length byte is 0
  logic [7:0] idx_q, idx_d;          // offset of the next data byte from BASE_ADDR
  logic       in_ready_q, in_ready_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       cpu_hold_q, cpu_hold_d;
  logic       done_q, done_d;
  logic       accept_s;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       error_q, error_d;
`endif

  // in_ready_q always mirrors "state_q is LEN/DATA/CSUM", so acceptance is a clean AND.
  assign accept_s = bus.in_valid & in_ready_q;

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
`ifdef PROG_LOADER_CSUM_EN
      ST_IDLE, ST_DONE, ST_ERR: begin
`else
      ST_IDLE, ST_DONE: begin
`endif
        if (start_i) begin
          state_d = ST_LEN;
          idx_d   = 8'h00;
`ifdef PROG_LOADER_CSUM_EN
          csum_d  = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          count_d = (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
          state_d = ST_DATA;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR + idx_q;
          mem_wdata_d = bus.in_data;
          idx_d       = idx_q + 8'd1;
          count_d     = count_q - 9'd1;
`ifdef PROG_LOADER_CSUM_EN
          csum_d      = csum_q + bus.in_data;
          state_d     = (count_q == 9'd1) ? ST_CSUM : ST_DATA;
`else
          state_d     = (count_q == 9'd1) ? ST_DONE : ST_DATA;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM: begin
        if (accept_s) begin
          state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they change with the state.
    in_ready_d = 1'b0;
    done_d     = 1'b0;
    cpu_hold_d = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
    error_d    = 1'b0;
`endif
    case (state_d)
      ST_LEN, ST_DATA: in_ready_d = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM:         in_ready_d = 1'b1;
      ST_ERR:          error_d    = 1'b1;
`endif
      ST_DONE: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      default: in_ready_d = 1'b0;
    endcase
  end

  // State and output registers; reset wins over any same-cycle start or byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= 9'd0;
      idx_q       <= 8'h00;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 8'h00;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= 8'h00;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= csum_d;
      error_q     <= error_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold_o    = cpu_hold_q;
  assign done_o        = done_q;
`ifdef PROG_LOADER_CSUM_EN
  assign error_o       = error_q;
`else
  assign error_o       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Two instances, with BASE_ADDR 00 and FE,
// share one stimulus stream. Expected memory writes go into per-instance
// queues when a data byte is accepted. They are popped when mem_we is seen.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       tb_valid;
  logic [7:0] tb_data;
  logic       hold0, done0, err0, hold1, done1, err1;

  int n_cmp = 0;
  int n_bad = 0;
  int idx   = 0;
  int we0   = 0;
  int we1   = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 clk = ~clk;

  prog_loader_if if0();
  prog_loader_if if1();
  assign if0.in_valid = tb_valid;
  assign if0.in_data  = tb_data;
  assign if1.in_valid = tb_valid;
  assign if1.in_data  = tb_data;

  prog_loader #(.BASE_ADDR(8'h00)) u0 (
    .clk(clk), .reset(reset), .start_i(start), .bus(if0),
    .cpu_hold_o(hold0), .done_o(done0), .error_o(err0)
  );
  prog_loader #(.BASE_ADDR(8'hFE)) u1 (
    .clk(clk), .reset(reset), .start_i(start), .bus(if1),
    .cpu_hold_o(hold1), .done_o(done1), .error_o(err1)
  );

  typedef struct {
    logic [7:0]      len;
    logic [3:0][7:0] d;      // d[0] is sent first
    logic [7:0]      cs;
    bit              stall;
    bit              exp_err; // outcome when the checksum byte is in use
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every mem_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    logic [15:0] e;
    if (if0.mem_we === 1'b1) begin
      we0++;
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr0_unexpected: got %0h:%0h expected no write", if0.mem_addr, if0.mem_wdata);
      end else begin
        e = q0.pop_front();
        chk("wr0", {if0.mem_addr, if0.mem_wdata}, {16'h0, e});
      end
    end
    if (if1.mem_we === 1'b1) begin
      we1++;
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr1_unexpected: got %0h:%0h expected no write", if1.mem_addr, if1.mem_wdata);
      end else begin
        e = q1.pop_front();
        chk("wr1", {if1.mem_addr, if1.mem_wdata}, {16'h0, e});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tb_valid = 1'b0;
      start    = 1'b0;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    tb_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    idx      = 0;
  endtask

  // Offer one byte and wait (bounded) for it to be accepted.
  task automatic send(input logic [7:0] b, input bit stall, input bit is_data);
    bit ok;
    logic [7:0] a1;
    @(negedge clk);
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        tb_valid = 1'b0;
        @(negedge clk);
      end
    end
    tb_valid = 1'b1;
    tb_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (if0.in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL accept_timeout: got no in_ready expected byte %0h accepted", b);
    end else if (is_data) begin
      a1 = 8'hFE + 8'(idx);
      q0.push_back({8'(idx), b});
      q1.push_back({a1, b});
      idx++;
    end
  endtask

  task automatic check_end(input bit e, input string tag);
    chk({tag, "_done0"}, done0, !e);
    chk({tag, "_err0"},  err0,  e);
    chk({tag, "_hold0"}, hold0, e);
    chk({tag, "_rdy0"},  if0.in_ready, 1'b0);
    chk({tag, "_done1"}, done1, !e);
    chk({tag, "_err1"},  err1,  e);
    chk({tag, "_hold1"}, hold1, e);
    chk({tag, "_q0"},    q0.size(), 0);
    chk({tag, "_q1"},    q1.size(), 0);
  endtask

  task automatic run_image(input vec_t v, input string tag);
    bit e;
    do_start();
    chk({tag, "_hold_armed"}, hold0, 1'b1);
    chk({tag, "_done_clr"},   done0, 1'b0);
    send(v.len, 1'b0, 1'b0);
    for (int i = 0; i < int'(v.len); i++) send(v.d[i], v.stall, 1'b1);
`ifdef PROG_LOADER_CSUM_EN
    send(v.cs, v.stall, 1'b0);
    e = v.exp_err;
`else
    e = 1'b0;
`endif
    idle(3);
    check_end(e, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{len:8'h03, d:{8'h00, 8'hF0, 8'h2B, 8'h1A}, cs:8'h35, stall:1'b0, exp_err:1'b0};
    vecs[1] = '{len:8'h02, d:{8'h00, 8'h00, 8'h22, 8'h11}, cs:8'h00, stall:1'b0, exp_err:1'b1};
    vecs[2] = '{len:8'h04, d:{8'h04, 8'h03, 8'h02, 8'h01}, cs:8'h0A, stall:1'b1, exp_err:1'b0};
    vecs[3] = '{len:8'h03, d:{8'h00, 8'hF0, 8'h2B, 8'h1A}, cs:8'h35, stall:1'b1, exp_err:1'b0};
    vecs[4] = '{len:8'h01, d:{8'h00, 8'h00, 8'h00, 8'hFF}, cs:8'hFF, stall:1'b0, exp_err:1'b0};

    // Reset with start and in_valid also high: reset must win.
    reset = 1'b1; start = 1'b1; tb_valid = 1'b1; tb_data = 8'h05;
    repeat (3) @(negedge clk);
    chk("rst_rdy",   if0.in_ready, 1'b0);
    chk("rst_we",    if0.mem_we, 1'b0);
    chk("rst_addr0", if0.mem_addr, 8'h00);
    chk("rst_addr1", if1.mem_addr, 8'hFE);
    chk("rst_wdata", if0.mem_wdata, 8'h00);
    chk("rst_hold",  hold0, 1'b1);
    chk("rst_done",  done0, 1'b0);
    chk("rst_err",   err0, 1'b0);
    reset = 1'b0; start = 1'b0;
    idle(2);
    chk("idle_rdy", if0.in_ready, 1'b0);

    for (int k = 0; k < 5; k++) run_image(vecs[k], $sformatf("vec%0d", k));

    // Bytes offered after completion are ignored.
    @(negedge clk);
    tb_valid = 1'b1; tb_data = 8'h33;
    repeat (4) @(negedge clk);
    chk("post_rdy",  if0.in_ready, 1'b0);
    chk("post_done", done0, 1'b1);
    idle(1);

    // Full 256-byte image (length byte 0) with an ignored start mid-load.
    we0 = 0; we1 = 0;
    do_start();
    send(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1'b0, 1'b1);
      if (i == 10) begin
        @(negedge clk);
        tb_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
`ifdef PROG_LOADER_CSUM_EN
    send(8'h80, 1'b0, 1'b0);
`endif
    idle(3);
    chk("len256_we0", we0, 256);
    chk("len256_we1", we1, 256);
    check_end(1'b0, "len256");

    // Reset after the 2nd of 4 data bytes, with a 3rd byte offered in the reset cycle.
    do_start();
    send(8'h04, 1'b0, 1'b0);
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1; tb_valid = 1'b1; tb_data = 8'h33;
    @(negedge clk);
    reset = 1'b0; tb_valid = 1'b0;
    chk("abort_hold", hold0, 1'b1);
    chk("abort_rdy",  if0.in_ready, 1'b0);
    chk("abort_done", done0, 1'b0);
    idle(4);
    chk("abort_q0", q0.size(), 0);
    run_image(vecs[0], "reload");

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00: first program-memory address written.
REQ-002 clk  input  1  clock; reset synchronous, active-high, clock clk.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle pulse that arms a load; honoured only in IDLE, DONE or ERR.
REQ-005 in_valid  input  1  byte-stream valid from host link.
REQ-006 in_data  input  8  byte-stream payload.
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 mem_we  output  1  program-memory write strobe, one cycle per instruction byte.
REQ-009 mem_addr  output  8  program-memory write address.
REQ-010 mem_wdata  output  8  program-memory write data (opcode[7:4], operand[3:0]).
REQ-011 cpu_hold  output  1  drives the processor reset; high while no valid image is loaded.
REQ-012 done  output  1  image loaded successfully; level.
REQ-013 error  output  1  load failed; level.

Function
REQ-014 A byte is accepted on any rising clk where in_valid and in_ready are both high; accepted bytes are never dropped or duplicated.
REQ-015 States: IDLE, LEN, DATA, CSUM, DONE, ERR; in_ready high only in LEN, DATA and CSUM.
REQ-016 IDLE/DONE/ERR + start -> LEN; done, error cleared and cpu_hold set in the cycle after start.
REQ-017 LEN: accepted byte loads the 9-bit remaining-count register; value 0 means 256 bytes; -> DATA.
REQ-018 DATA: each accepted byte is written with mem_we high exactly one cycle later, mem_addr = BASE_ADDR + index (8-bit wrap-around), mem_wdata = the byte; the count decrements.
REQ-019 DATA: acceptance of the last byte (count reaching 0) -> CSUM (macro defined) or DONE (macro undefined).
REQ-020 Running checksum = 8-bit modulo-256 sum of all DATA bytes, cleared on entry to LEN.
REQ-021 CSUM: accepted byte equal to the running sum -> DONE; mismatch -> ERR.
REQ-022 DONE: done=1, cpu_hold=0; remains until start or reset.
REQ-023 ERR: error=1, cpu_hold=1; remains until start or reset; memory already written is not rolled back.
REQ-024 start outside IDLE/DONE/ERR is ignored; in_valid outside LEN/DATA/CSUM is ignored.
REQ-025 in_valid low inside LEN/DATA/CSUM stalls with no state change and no timeout.
REQ-026 mem_we is never high in two consecutive cycles unless two bytes were accepted in consecutive cycles; maximum throughput is one byte per clk.
REQ-027 cpu_hold is a registered output with no combinational path from any input.

Reset
REQ-028 reset -> IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0, count=0, checksum=0.
REQ-029 reset asserted mid-load aborts the load in the same edge; no mem_we pulse follows reset, even for a byte accepted in the preceding cycle.
REQ-030 reset takes priority over start and in_valid in the same cycle.

Configuration
REQ-031 Macro PROG_LOADER_CSUM_EN defined: CSUM state and checksum check present as specified in REQ-019 to REQ-021.
REQ-032 PROG_LOADER_CSUM_EN undefined: CSUM state and checksum logic absent; the last DATA byte -> DONE; ERR is unreachable; error is tied to 0.

Verification
REQ-033 start, stream 03,1A,2B,F0,35 (csum) with in_valid constant -> writes 00:1A, 01:2B, 02:F0; done=1; cpu_hold=0.
REQ-034 start, stream 02,11,22,00 (bad csum, expected 33) -> two writes, then error=1, cpu_hold=1, done=0.
REQ-035 BASE_ADDR=8'hFE, length 03 -> writes to FE, FF, 00 (wrap); length 00 -> exactly 256 mem_we pulses.
REQ-036 in_valid toggled randomly during DATA -> written data and addresses identical to the back-to-back case; no extra mem_we.
REQ-037 reset asserted after the 2nd of 4 data bytes -> IDLE, cpu_hold=1, no further mem_we; a subsequent start with a full image completes.
REQ-038 Macro undefined: stream 02,11,22 -> done=1 immediately after the 2nd write; a trailing byte 33 is not accepted (in_ready=0).
